fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: single-issue instruction fetch stage.
// Drives an instruction ROM from the program counter and captures one word per
// cycle into an instruction register, with a valid/ready handshake to decode.
// A taken branch/jump (redirect) flushes the held instruction and reloads the pc.
// Optional feature macro: FETCH_BOUNDS_CHECK_EN
//   defined   -> a fetch outside [RESET_PC, ROM_LAST] latches a sticky fault
//                and the unit stops until reset.
//   undefined -> fault is tied low and any 16-bit address is fetched.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h8000,
    parameter logic [15:0] ROM_LAST = 16'h8FFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [15:0] rom_addr,
    output logic        rom_oe,
    input  logic [31:0] rom_data,
    output logic [31:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic [15:0] pc_reg;
    logic [31:0] instr_reg;
    logic [15:0] instr_pc_reg;
    logic        valid_reg;

    // A fetch is wanted when running, allowed, not being flushed, and the
    // instruction register is empty or is being drained this cycle.
    logic        fetch_ok;
    logic        out_of_range;
    logic        load;
    logic        fault_hit;

    assign fetch_ok = (state_reg == RUN) & enable & ~redirect
                    & (~valid_reg | instr_ready);

`ifdef FETCH_BOUNDS_CHECK_EN
    assign out_of_range = (pc_reg < RESET_PC) | (pc_reg > ROM_LAST);
`else
    assign out_of_range = 1'b0;
`endif

    // An out-of-range fetch never reaches the ROM; it becomes a fault instead.
    assign load      = fetch_ok & ~out_of_range;
    assign fault_hit = fetch_ok &  out_of_range;

    // ROM interface is purely combinational from the current pc.
    assign rom_addr    = pc_reg;
    assign rom_oe      = load;

    assign instr       = instr_reg;
    assign instr_pc    = instr_pc_reg;
    assign instr_valid = valid_reg;

`ifdef FETCH_BOUNDS_CHECK_EN
    // FAULT is only left through reset, so the state itself is the sticky flag.
    assign fault = (state_reg == FAULT);
`else
    assign fault = 1'b0;
`endif

    // State register; reset parks the unit in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: one idle cycle after reset, then run until a fault.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = RUN;
            RUN:     if (fault_hit) state_next = FAULT;
            FAULT:   state_next = FAULT;
            default: state_next = IDLE;
        endcase
    end

    // Fetch datapath: redirect beats fault/load/handshake; a stalled
    // instruction (valid and not ready) falls through every branch and holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg       <= RESET_PC;
            instr_reg    <= 32'h0;
            instr_pc_reg <= 16'h0;
            valid_reg    <= 1'b0;
        end else if ((state_reg == RUN) && redirect) begin
            pc_reg    <= redirect_pc;
            valid_reg <= 1'b0;
        end else if (fault_hit) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            instr_reg    <= rom_data;
            instr_pc_reg <= pc_reg;
            valid_reg    <= 1'b1;
            pc_reg       <= pc_reg + 16'd1;
        end else if (instr_ready) begin
            valid_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// Directed vector table (streaming, stall, redirect, enable, wrap or fault),
// asynchronous mid-stream reset sequence, then randomized traffic against a
// behavioural model of the fetch rules. Honours FETCH_BOUNDS_CHECK_EN.
module tb_fetch_unit;

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic [15:0] rom_addr;
    logic        rom_oe;
    logic [31:0] rom_data;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        fault;

    int checks = 0;
    int failures = 0;

    fetch_unit #(.RESET_PC(16'h8000), .ROM_LAST(16'h8FFF)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .rom_addr(rom_addr), .rom_oe(rom_oe), .rom_data(rom_data),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redirect(redirect),
        .redirect_pc(redirect_pc), .fault(fault)
    );

    always #5 clk = ~clk;

    // ROM contents: each word encodes its own address so captures are traceable.
    function automatic logic [31:0] rom_fn(input logic [15:0] a);
        return {a ^ 16'hA5C3, a};
    endfunction

    assign rom_data = rom_fn(rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        en;
        logic        rdy;
        logic        redir;
        logic [15:0] rpc;
        logic        exp_oe;
        logic [15:0] exp_addr;
        logic        exp_valid;
        logic [15:0] exp_ipc;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic en, input logic rdy, input logic redir,
                                input logic [15:0] rpc, input logic oe,
                                input logic [15:0] addr, input logic valid,
                                input logic [15:0] ipc, input logic flt);
        vec_t v;
        v.en = en; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
        v.exp_oe = oe; v.exp_addr = addr; v.exp_valid = valid;
        v.exp_ipc = ipc; v.exp_fault = flt;
        return v;
    endfunction

    // Hold reset for two cycles and release on a falling edge with inputs idle.
    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        instr_ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = 16'h0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Behavioural model state
    bit          m_started;
    bit          m_faulted;
    logic [15:0] m_pc;
    bit          m_valid;
    logic [15:0] m_ipc;

    initial begin
        // ---------------- reset values ----------------
        @(negedge clk);
        @(negedge clk);
        chk("reset_rom_oe", rom_oe, 1'b0);
        chk("reset_rom_addr", rom_addr, 16'h8000);
        chk("reset_valid", instr_valid, 1'b0);
        chk("reset_instr", instr, 32'h0);
        chk("reset_instr_pc", instr_pc, 16'h0);
        chk("reset_fault", fault, 1'b0);

        // ---------------- directed table ----------------
        vecs.push_back(mk(1, 1, 0, 16'h0,    0, 16'h8000, 0, 16'h0000, 0));
        vecs.push_back(mk(1, 1, 0, 16'h0,    1, 16'h8000, 1, 16'h8000, 0));
        vecs.push_back(mk(1, 1, 0, 16'h0,    1, 16'h8001, 1, 16'h8001, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0,    0, 16'h8002, 1, 16'h8001, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0,    0, 16'h8002, 1, 16'h8001, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0,    0, 16'h8002, 1, 16'h8001, 0));
        vecs.push_back(mk(1, 1, 0, 16'h0,    1, 16'h8002, 1, 16'h8002, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0,    0, 16'h8003, 1, 16'h8002, 0));
        vecs.push_back(mk(1, 0, 1, 16'h8010, 0, 16'h8003, 0, 16'h8002, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0,    1, 16'h8010, 1, 16'h8010, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0,    0, 16'h8011, 0, 16'h8010, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 16'h8011, 0, 16'h8010, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0,    1, 16'h8011, 1, 16'h8011, 0));
`ifdef FETCH_BOUNDS_CHECK_EN
        vecs.push_back(mk(1, 1, 1, 16'h9000, 0, 16'h8012, 0, 16'h8011, 0));
        vecs.push_back(mk(1, 1, 0, 16'h0,    0, 16'h9000, 0, 16'h8011, 1));
        vecs.push_back(mk(1, 1, 1, 16'h8000, 0, 16'h9000, 0, 16'h8011, 1));
        vecs.push_back(mk(1, 1, 0, 16'h0,    0, 16'h9000, 0, 16'h8011, 1));
        vecs.push_back(mk(1, 0, 0, 16'h0,    0, 16'h9000, 0, 16'h8011, 1));
`else
        vecs.push_back(mk(1, 1, 1, 16'hFFFF, 0, 16'h8012, 0, 16'h8011, 0));
        vecs.push_back(mk(1, 1, 0, 16'h0,    1, 16'hFFFF, 1, 16'hFFFF, 0));
        vecs.push_back(mk(1, 1, 0, 16'h0,    1, 16'h0000, 1, 16'h0000, 0));
        vecs.push_back(mk(1, 1, 0, 16'h0,    1, 16'h0001, 1, 16'h0001, 0));
`endif

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            enable      = vecs[i].en;
            instr_ready = vecs[i].rdy;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            #1;
            chk($sformatf("vec%0d_rom_oe", i), rom_oe, vecs[i].exp_oe);
            chk($sformatf("vec%0d_rom_addr", i), rom_addr, vecs[i].exp_addr);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", i), instr_valid, vecs[i].exp_valid);
            chk($sformatf("vec%0d_instr_pc", i), instr_pc, vecs[i].exp_ipc);
            chk($sformatf("vec%0d_fault", i), fault, vecs[i].exp_fault);
            if (vecs[i].exp_valid)
                chk($sformatf("vec%0d_instr", i), instr, rom_fn(vecs[i].exp_ipc));
            $display("vec %0d en=%0b rdy=%0b redir=%0b rpc=%h -> valid=%0b instr_pc=%h fault=%0b",
                     i, vecs[i].en, vecs[i].rdy, vecs[i].redir, vecs[i].rpc,
                     instr_valid, instr_pc, fault);
            @(negedge clk);
        end
        redirect = 1'b0;

`ifdef FETCH_BOUNDS_CHECK_EN
        // Fault is sticky until a reset pulse clears it.
        rst_n = 1'b0;
        #1;
        chk("fault_cleared_by_reset", fault, 1'b0);
        chk("fault_reset_rom_addr", rom_addr, 16'h8000);
        $display("fault pulse: rst_n low -> fault=%0b rom_addr=%h", fault, rom_addr);
`endif

        // ---------------- asynchronous reset mid-stream ----------------
        do_reset();
        enable = 1'b1;
        instr_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("stream_valid", instr_valid, 1'b1);
        chk("stream_instr_pc", instr_pc, 16'h8002);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", instr_valid, 1'b0);
        chk("async_rst_instr", instr, 32'h0);
        chk("async_rst_instr_pc", instr_pc, 16'h0);
        chk("async_rst_rom_oe", rom_oe, 1'b0);
        chk("async_rst_rom_addr", rom_addr, 16'h8000);
        chk("async_rst_fault", fault, 1'b0);
        $display("async reset: valid=%0b instr_pc=%h rom_oe=%0b rom_addr=%h",
                 instr_valid, instr_pc, rom_oe, rom_addr);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_idle_rom_oe", rom_oe, 1'b0);
        @(negedge clk);
        #1;
        chk("post_rst_run_rom_oe", rom_oe, 1'b1);
        chk("post_rst_run_rom_addr", rom_addr, 16'h8000);
        $display("post reset: rom_oe=%0b rom_addr=%h", rom_oe, rom_addr);
        @(negedge clk);

        // ---------------- randomized traffic vs model ----------------
        do_reset();
        m_started = 0;
        m_faulted = 0;
        m_pc      = 16'h8000;
        m_valid   = 0;
        m_ipc     = 16'h0;
        for (int c = 0; c < 400; c++) begin
            bit want_fetch;
            bit in_rom;
            bit exp_oe;
            enable      = ($urandom_range(0, 3) != 0);
            instr_ready = ($urandom_range(0, 2) != 0);
            redirect    = ($urandom_range(0, 9) == 0);
            if (!BOUNDS && ($urandom_range(0, 3) == 0))
                redirect_pc = 16'hFFF0 + 16'($urandom_range(0, 15));
            else
                redirect_pc = 16'h8000 + 16'($urandom_range(0, 16'h0F00));
            #1;
            want_fetch = m_started && !m_faulted && enable && !redirect
                         && (!m_valid || instr_ready);
            in_rom = !BOUNDS || (m_pc >= 16'h8000 && m_pc <= 16'h8FFF);
            exp_oe = want_fetch && in_rom;
            chk($sformatf("rnd%0d_rom_oe", c), rom_oe, exp_oe);
            chk($sformatf("rnd%0d_rom_addr", c), rom_addr, m_pc);
            @(posedge clk);
            #1;
            if (!m_started) begin
                m_started = 1;
            end else if (m_faulted) begin
                m_faulted = 1;
            end else if (redirect) begin
                m_pc = redirect_pc;
                m_valid = 0;
            end else if (want_fetch && !in_rom) begin
                m_faulted = 1;
                m_valid = 0;
            end else if (want_fetch) begin
                m_ipc = m_pc;
                m_valid = 1;
                m_pc = m_pc + 16'd1;
            end else if (instr_ready) begin
                m_valid = 0;
            end
            chk($sformatf("rnd%0d_valid", c), instr_valid, m_valid);
            chk($sformatf("rnd%0d_fault", c), fault, m_faulted);
            if (m_valid) begin
                chk($sformatf("rnd%0d_instr_pc", c), instr_pc, m_ipc);
                chk($sformatf("rnd%0d_instr", c), instr, rom_fn(m_ipc));
            end
            $display("rnd %0d en=%0b rdy=%0b redir=%0b rpc=%h -> valid=%0b instr_pc=%h fault=%0b",
                     c, enable, instr_ready, redirect, redirect_pc,
                     instr_valid, instr_pc, fault);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
